// File: rtl/phy_tx_pkg.sv
// Shared symbols, state encoding and lane types for the PHY TX byte scheduler.
// Constants only; no latency or flow control of its own.
package phy_tx_pkg;

  localparam logic [7:0] COM = 8'hBC;
  localparam logic [7:0] IDL = 8'h7C;

  localparam int unsigned LANE_W = 1;
  typedef logic [LANE_W-1:0] lane_t;
  localparam lane_t LANE0 = lane_t'(0);
  localparam lane_t LANE1 = lane_t'(1);

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_PAUSE  = 2'd2
  } sched_state_t;

endpackage

// File: rtl/phy_tx_sched_if.sv
// Two requester lanes plus the byte stream toward the serializer.
// Lane ready is combinational from the scheduler; the output side has no backpressure.
interface phy_tx_sched_if;
  import phy_tx_pkg::*;

  logic       valid0;
  logic [7:0] data0;
  logic       ready0;
  logic       valid1;
  logic [7:0] data1;
  logic       ready1;
  logic [7:0] data_out;
  logic       data_k;
  lane_t      lane_id;
  logic       synced;

  modport master (
    output valid0, data0, valid1, data1,
    input  ready0, ready1, data_out, data_k, lane_id, synced
  );

  modport slave (
    input  valid0, data0, valid1, data1,
    output ready0, ready1, data_out, data_k, lane_id, synced
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin grant: grant is combinational, pointer moves past the winner
// on each grant. Zero latency; a lane stays unserved while en is low.
module rr_arbiter2
  import phy_tx_pkg::*;
(
  input  logic       clk_4f,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt,
  output lane_t      gnt_lane,
  output logic       gnt_vld
);

  lane_t rr_ptr;

  always_comb begin
    gnt_lane = LANE0;
    if (req == 2'b10)
      gnt_lane = LANE1;
    else if (req == 2'b11)
      gnt_lane = rr_ptr;
  end

  assign gnt_vld = en & (|req);
  assign gnt     = gnt_vld ? ((gnt_lane == LANE1) ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset)
      rr_ptr <= LANE0;
    else if (gnt_vld)
      rr_ptr <= ~gnt_lane;
  end

endmodule

// File: rtl/phy_tx_sched.sv
// Byte scheduler feeding the TX serializer: COM sync burst, round-robin lanes, IDL fill.
// One cycle from lane handshake to data_out; lanes are held off by ready, serializer never stalls.
module phy_tx_sched
  import phy_tx_pkg::*;
#(
  parameter int unsigned N_SYNC = 4
) (
  input  logic             clk_4f,
  input  logic             reset,
  input  logic             tx_en,
  input  logic             resync,
  phy_tx_sched_if.slave    tx
);

  localparam logic [3:0] SYNC_N = 4'(N_SYNC);

  sched_state_t state;
  logic [3:0]   sync_cnt;
  logic [1:0]   gnt;
  lane_t        gnt_lane;
  logic         gnt_vld;
  logic         grant_en;
  logic [7:0]   gnt_dat;

  // resync and tx_en gate ready in the same cycle so a pending byte is never half-taken
  assign grant_en = (state == ST_ACTIVE) & tx_en & ~resync;

  rr_arbiter2 u_arb (
    .clk_4f   (clk_4f),
    .reset    (reset),
    .req      ({tx.valid1, tx.valid0}),
    .en       (grant_en),
    .gnt      (gnt),
    .gnt_lane (gnt_lane),
    .gnt_vld  (gnt_vld)
  );

  assign tx.ready0 = gnt[0];
  assign tx.ready1 = gnt[1];
  assign gnt_dat   = (gnt_lane == LANE1) ? tx.data1 : tx.data0;

  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      state       <= ST_SYNC;
      sync_cnt    <= 4'd0;
      tx.data_out <= COM;
      tx.data_k   <= 1'b1;
      tx.lane_id  <= LANE0;
      tx.synced   <= 1'b0;
    end else if (resync) begin
      state       <= ST_SYNC;
      sync_cnt    <= 4'd0;
      tx.data_out <= COM;
      tx.data_k   <= 1'b1;
      tx.lane_id  <= LANE0;
      tx.synced   <= 1'b0;
    end else begin
      tx.data_out <= IDL;
      tx.data_k   <= 1'b1;
      tx.lane_id  <= LANE0;
      case (state)
        ST_SYNC: begin
          if (sync_cnt < SYNC_N) begin
            sync_cnt    <= sync_cnt + 4'd1;
            tx.data_out <= COM;
          end else begin
            state     <= tx_en ? ST_ACTIVE : ST_PAUSE;
            tx.synced <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (!tx_en) begin
            state <= ST_PAUSE;
          end else if (gnt_vld) begin
            tx.data_out <= gnt_dat;
            tx.data_k   <= 1'b0;
            tx.lane_id  <= gnt_lane;
          end
        end
        ST_PAUSE: begin
          if (tx_en)
            state <= ST_ACTIVE;
        end
        default: begin
          state       <= ST_SYNC;
          sync_cnt    <= 4'd0;
          tx.data_out <= COM;
          tx.synced   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phy_tx_sched.sv
// Directed bench for phy_tx_sched: expected bytes are queued as stimulus is applied
// and compared one per clock as the scheduler registers its output.
module tb_phy_tx_sched;
  import phy_tx_pkg::*;

  typedef struct packed {
    logic [7:0] d;
    logic       k;
    logic       l;
    logic       s;
  } exp_t;

  logic clk_4f = 1'b0;
  logic reset  = 1'b0;
  logic tx_en  = 1'b0;
  logic resync = 1'b0;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  phy_tx_sched_if lanes ();

  phy_tx_sched #(.N_SYNC(4)) dut (
    .clk_4f (clk_4f),
    .reset  (reset),
    .tx_en  (tx_en),
    .resync (resync),
    .tx     (lanes)
  );

  always #5 clk_4f = ~clk_4f;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] d, input logic k, input logic l, input logic s);
    exp_t e;
    e.d = d; e.k = k; e.l = l; e.s = s;
    return e;
  endfunction

  // Called just after a rising edge with inputs already driven: check ready,
  // queue the byte due at the next edge, then compare it once it is registered.
  task automatic step(input string tag, input logic r0, input logic r1, input exp_t e);
    exp_t got;
    #1;
    chk({tag, ".ready0"}, {7'd0, lanes.ready0}, {7'd0, r0});
    chk({tag, ".ready1"}, {7'd0, lanes.ready1}, {7'd0, r1});
    sb.push_back(e);
    @(posedge clk_4f);
    #1;
    got = sb.pop_front();
    chk({tag, ".data_out"}, lanes.data_out, got.d);
    chk({tag, ".data_k"},   {7'd0, lanes.data_k},  {7'd0, got.k});
    chk({tag, ".lane_id"},  {7'd0, lanes.lane_id}, {7'd0, got.l});
    chk({tag, ".synced"},   {7'd0, lanes.synced},  {7'd0, got.s});
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".data_out"}, lanes.data_out, 8'hBC);
    chk({tag, ".data_k"},   {7'd0, lanes.data_k},  8'd1);
    chk({tag, ".lane_id"},  {7'd0, lanes.lane_id}, 8'd0);
    chk({tag, ".synced"},   {7'd0, lanes.synced},  8'd0);
    chk({tag, ".ready0"},   {7'd0, lanes.ready0},  8'd0);
    chk({tag, ".ready1"},   {7'd0, lanes.ready1},  8'd0);
  endtask

  initial begin
    lanes.valid0 = 1'b0; lanes.data0 = 8'h00;
    lanes.valid1 = 1'b0; lanes.data1 = 8'h00;

    // reset state
    repeat (2) @(posedge clk_4f);
    #1;
    chk_reset_vals("rst");

    // sync after reset release, tx_en=1, no lanes valid
    reset = 1'b1;
    tx_en = 1'b1;
    for (int i = 0; i < 4; i++) step("sync", 1'b0, 1'b0, mk(8'hBC, 1'b1, 1'b0, 1'b0));
    step("sync_done", 1'b0, 1'b0, mk(8'h7C, 1'b1, 1'b0, 1'b1));
    step("idle0", 1'b0, 1'b0, mk(8'h7C, 1'b1, 1'b0, 1'b1));
    step("idle1", 1'b0, 1'b0, mk(8'h7C, 1'b1, 1'b0, 1'b1));

    // both lanes valid: pointer starts at lane 0
    lanes.valid0 = 1'b1; lanes.data0 = 8'h11;
    lanes.valid1 = 1'b1; lanes.data1 = 8'h22;
    for (int i = 0; i < 2; i++) begin
      step("rr_l0", 1'b1, 1'b0, mk(8'h11, 1'b0, 1'b0, 1'b1));
      step("rr_l1", 1'b0, 1'b1, mk(8'h22, 1'b0, 1'b1, 1'b1));
    end
    lanes.valid0 = 1'b0; lanes.valid1 = 1'b0;
    step("rr_idle", 1'b0, 1'b0, mk(8'h7C, 1'b1, 1'b0, 1'b1));

    // lane 0 alone, back to back
    lanes.valid0 = 1'b1; lanes.data0 = 8'hA5;
    step("l0_a5", 1'b1, 1'b0, mk(8'hA5, 1'b0, 1'b0, 1'b1));
    lanes.data0 = 8'h3C;
    step("l0_3c", 1'b1, 1'b0, mk(8'h3C, 1'b0, 1'b0, 1'b1));
    lanes.valid0 = 1'b0;
    step("l0_idle", 1'b0, 1'b0, mk(8'h7C, 1'b1, 1'b0, 1'b1));

    // last grant was lane 0, so lane 1 wins first; then pause/resume
    lanes.valid0 = 1'b1; lanes.data0 = 8'h55;
    lanes.valid1 = 1'b1; lanes.data1 = 8'h66;
    step("pre_pause", 1'b0, 1'b1, mk(8'h66, 1'b0, 1'b1, 1'b1));
    tx_en = 1'b0;
    step("pause_edge", 1'b0, 1'b0, mk(8'h7C, 1'b1, 1'b0, 1'b1));
    step("pause_hold", 1'b0, 1'b0, mk(8'h7C, 1'b1, 1'b0, 1'b1));
    tx_en = 1'b1;
    step("resume_edge", 1'b0, 1'b0, mk(8'h7C, 1'b1, 1'b0, 1'b1));
    step("resume_l0", 1'b1, 1'b0, mk(8'h55, 1'b0, 1'b0, 1'b1));
    step("resume_l1", 1'b0, 1'b1, mk(8'h66, 1'b0, 1'b1, 1'b1));
    lanes.valid0 = 1'b0; lanes.valid1 = 1'b0;
    step("resume_idle", 1'b0, 1'b0, mk(8'h7C, 1'b1, 1'b0, 1'b1));

    // resync during lane 1 traffic: held byte survives the sync burst
    lanes.valid1 = 1'b1; lanes.data1 = 8'h77;
    step("l1_77", 1'b0, 1'b1, mk(8'h77, 1'b0, 1'b1, 1'b1));
    lanes.data1 = 8'h88;
    resync = 1'b1;
    step("resync_edge", 1'b0, 1'b0, mk(8'hBC, 1'b1, 1'b0, 1'b0));
    resync = 1'b0;
    for (int i = 0; i < 4; i++) step("resync_com", 1'b0, 1'b0, mk(8'hBC, 1'b1, 1'b0, 1'b0));
    step("resync_done", 1'b0, 1'b0, mk(8'h7C, 1'b1, 1'b0, 1'b1));
    step("l1_88", 1'b0, 1'b1, mk(8'h88, 1'b0, 1'b1, 1'b1));
    lanes.valid1 = 1'b0;
    step("l1_idle", 1'b0, 1'b0, mk(8'h7C, 1'b1, 1'b0, 1'b1));

    // asynchronous reset mid-stream
    lanes.valid0 = 1'b1; lanes.data0 = 8'h99;
    step("l0_99", 1'b1, 1'b0, mk(8'h99, 1'b0, 1'b0, 1'b1));
    lanes.data0 = 8'h9A;
    #2;
    reset = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    @(posedge clk_4f);
    #1;
    chk_reset_vals("rst_hold");
    reset = 1'b1;
    for (int i = 0; i < 4; i++) step("rst_sync", 1'b0, 1'b0, mk(8'hBC, 1'b1, 1'b0, 1'b0));
    step("rst_sync_done", 1'b0, 1'b0, mk(8'h7C, 1'b1, 1'b0, 1'b1));
    step("l0_9a", 1'b1, 1'b0, mk(8'h9A, 1'b0, 1'b0, 1'b1));
    lanes.valid0 = 1'b0;
    step("final_idle", 1'b0, 1'b0, mk(8'h7C, 1'b1, 1'b0, 1'b1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
